dht22_seg7_display: RTL
=======================

# dht22_seg7_display

Downstream consumer of the DHT22 reader: captures each completed reading (BCD humidity, BCD temperature, sign) on the reader's `data_ready` pulse and shows it on an 8-digit multiplexed common-anode 7-segment display. Temperature is on digits 7..4 and humidity on digits 3..0, one decimal place each. If no reading arrives within a timeout, the display falls back to dashes. The block sits between `top_dht22` and the board's display pins.

## Interface
- `CLK_FREQ`, 100000000: clock frequency in Hz.
- `REFRESH_HZ`, 1000: full-frame refresh rate. Digit tick period is `CLK_FREQ/(REFRESH_HZ*8)` cycles, minimum 1.
- `STALE_MS`, 5000: time without `data_ready` before the display reverts to dashes.
- `clk`, in, 1: the single clock. All logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `data_ready`, in, 1: one-cycle pulse meaning the BCD inputs hold a new valid reading.
- `humidity_bcd`, in, [2:0][3:0]: humidity digits; [2]=tens, [1]=units, [0]=tenths.
- `negativo_temp`, in, 1: 1 when the temperature is negative.
- `temperature_bcd`, in, [2:0][3:0]: temperature digits; [2]=tens, [1]=units, [0]=tenths.
- `seg_n`, out, 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp_n`, out, 1: decimal point, active-low.
- `an_n`, out, 8: digit enables, active-low, one-hot-low.
- `valid`, out, 1: high while the display shows a live (non-stale) reading.

## Operation
- **Capture**
  - On `data_ready`=1, register all seven input fields together.
  - Set `valid`=1 and reload the stale counter to `STALE_MS*(CLK_FREQ/1000)-1`.
  - The inputs are don't-care in every other cycle.
- **Staleness**
  - While `valid`=1 and `data_ready`=0, the stale counter decrements once per cycle.
  - When it reaches 0, clear `valid` in the next cycle.
  - `data_ready` in the same cycle as expiry wins: the counter reloads and `valid` stays 1.
- **Scan**
  - A tick counter counts 0..TICK-1. On wrap, the digit index (3 bits) increments, wrapping 7→0.
  - The active digit is `an_n = ~(8'b1 << idx)`.
- **Digit content when `valid`=1**
  - idx7: `-` if `negativo_temp`, else blank.
  - idx6: temperature tens; blank if it is 0.
  - idx5: temperature units, with `dp_n`=0.
  - idx4: temperature tenths.
  - idx3: blank.
  - idx2: humidity tens; blank if it is 0.
  - idx1: humidity units, with `dp_n`=0.
  - idx0: humidity tenths.
- **Digit content when `valid`=0**
  - Every digit shows `-` (`7'b0111111`), with `dp_n`=1.
- **Decoder**
  - 0..9 use standard glyphs, e.g. `0`=`7'b1000000` and `8`=`7'b0000000`.
  - Any BCD value >9 shows `E` (`7'b0000110`).
  - Blank is `7'b1111111`.
- **Sign**
  - The sign is displayed as captured. "-0.0" shows `-` on idx7 and blank on idx6.

## Timing
- **Reset values**
  - `seg_n`=`7'b1111111`, `dp_n`=1, `an_n`=`8'hFE` (digit 0), `valid`=0.
  - Tick counter, digit index and stale counter are 0. Captured fields are 0.
- **Output registers**
  - `seg_n`, `dp_n` and `an_n` are registered and change together in the cycle after the index changes.
  - There is no cycle where two anodes are low.
- **Capture latency**
  - `valid` rises 1 cycle after `data_ready`.
  - The new value appears on the currently scanned digit 2 cycles after `data_ready`: capture, then output register.
  - Other digits show the new value at their next scan slot.
- **Reset mid-scan**
  - Everything returns to reset values in the next cycle. A captured reading is discarded.
- **Tick period**
  - Exactly TICK cycles per digit. With TICK=1 the index advances every cycle.

## Structure
- **Package `dht22_pkg`**
  - Segment constants: `SEG_BLANK`, `SEG_DASH`, `SEG_E`.
  - `typedef logic [2:0][3:0] bcd3_t`.
  - `typedef enum {GLYPH_DIGIT, GLYPH_BLANK, GLYPH_DASH}` for digit-select.
- **Sub-module `seg7_decoder`**
  - Purely combinational: 4-bit BCD plus glyph select in, 7-bit active-low segments out.
  - Instantiated once, on the muxed digit.
- **Top body:** the capture registers, stale counter, tick/index counters and the output registers.

## Test plan
Parameters for all scenarios: `CLK_FREQ`=8000, `REFRESH_HZ`=100 (TICK=10), `STALE_MS`=10 (stale count 80).

1. **Reset.** Assert `rst` 3 cycles, then release → `valid`=0. All 8 digits cycle `an_n` FE,FD,…,7F, each held 10 cycles, each showing `seg_n`=`7'b0111111`.
2. **Positive reading.** Pulse `data_ready` with temperature 2,3,5, `negativo_temp`=0, humidity 6,7,8 → over one frame: idx7 blank, idx6 `2`, idx5 `3`+dp, idx4 `5`, idx3 blank, idx2 `6`, idx1 `7`+dp, idx0 `8`. `valid`=1 one cycle after the pulse.
3. **Negative, leading zero.** Temperature 0,4,1 with `negativo_temp`=1; humidity 0,9,9 → idx7 `-`, idx6 blank, idx5 `4`+dp; idx2 blank, idx1 `9`+dp.
4. **Stale timeout.** Reading, then no pulse for 80 cycles → `valid` falls at cycle 81 and all digits show dashes. A new pulse at cycle 79 instead → `valid` stays 1.
5. **Invalid BCD.** Humidity units = 4'hC → idx1 shows `E`+dp; other digits normal.
6. **Reset mid-scan.** `rst` while idx=5 with `valid`=1 → next cycle `an_n`=`8'hFE`, `seg_n`=`7'b1111111`, `valid`=0.

Source files
------------

// File: rtl/dht22_seg7_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dht22_pkg
//  Description : Shared types and segment constants for the DHT22 7-segment
//                display slice. Segment vectors are {g,f,e,d,c,b,a},
//                active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
package dht22_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    // Three BCD digits: [2]=tens, [1]=units, [0]=tenths
    typedef logic [2:0][3:0] bcd3_t;

    // What the decoder should draw for the currently scanned digit
    typedef enum logic [1:0] {
        GLYPH_DIGIT = 2'd0,
        GLYPH_BLANK = 2'd1,
        GLYPH_DASH  = 2'd2
    } glyph_t;

endpackage
`default_nettype wire

// File: rtl/dht22_seg7_display_seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder
//  Description : Combinational BCD / glyph to active-low 7-segment decoder.
//                Digits 0..9 use standard glyphs; values above 9 draw 'E'.
//  Ports       : i_bcd   - 4-bit BCD value (used when i_glyph = GLYPH_DIGIT)
//                i_glyph - digit, blank or dash select
//                o_seg   - segments {g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import dht22_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  glyph_t     i_glyph,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_glyph)
            GLYPH_DIGIT: begin
                case (i_bcd)
                    4'd0:    o_seg = 7'b1000000;
                    4'd1:    o_seg = 7'b1111001;
                    4'd2:    o_seg = 7'b0100100;
                    4'd3:    o_seg = 7'b0110000;
                    4'd4:    o_seg = 7'b0011001;
                    4'd5:    o_seg = 7'b0010010;
                    4'd6:    o_seg = 7'b0000010;
                    4'd7:    o_seg = 7'b1111000;
                    4'd8:    o_seg = 7'b0000000;
                    4'd9:    o_seg = 7'b0010000;
                    default: o_seg = SEG_E;
                endcase
            end
            GLYPH_DASH:  o_seg = SEG_DASH;
            default:     o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dht22_seg7_display.sv
`default_nettype none
// ============================================================================
//  Module      : dht22_seg7_display
//  Description : Captures DHT22 readings on data_ready and shows them on an
//                8-digit multiplexed common-anode 7-segment display.
//                Digits 7..4: sign, temperature tens/units(.)/tenths.
//                Digits 3..0: blank, humidity tens/units(.)/tenths.
//                Without a fresh reading for STALE_MS the display shows
//                dashes on every digit.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                data_ready      - one-cycle pulse, BCD inputs valid
//                humidity_bcd    - humidity digits [2]=tens..[0]=tenths
//                negativo_temp   - temperature sign (1 = negative)
//                temperature_bcd - temperature digits [2]=tens..[0]=tenths
//                seg_n, dp_n     - segments / decimal point, active-low
//                an_n            - digit enables, active-low, one-hot-low
//                valid           - a live reading is being displayed
//  Revision    : 1.0 - initial release
// ============================================================================
module dht22_seg7_display
    import dht22_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int REFRESH_HZ = 1000,
    parameter int STALE_MS   = 5000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_ready,
    input  logic [2:0][3:0]  humidity_bcd,
    input  logic             negativo_temp,
    input  logic [2:0][3:0]  temperature_bcd,
    output logic [6:0]       seg_n,
    output logic             dp_n,
    output logic [7:0]       an_n,
    output logic             valid
);

    // Per-digit scan period in clocks, never below one
    localparam int c_TICK_RAW = CLK_FREQ / (REFRESH_HZ * 8);
    localparam int c_TICK     = (c_TICK_RAW < 1) ? 1 : c_TICK_RAW;
    localparam int c_TICK_W   = (c_TICK > 1) ? $clog2(c_TICK) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(c_TICK - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE = c_TICK_W'(1);

    // Stale counter reload value; 64-bit math keeps large products exact
    localparam longint c_STALE_LOAD = longint'(STALE_MS) * longint'(CLK_FREQ / 1000) - 1;
    localparam int     c_STALE_W    = (c_STALE_LOAD > 0) ? $clog2(c_STALE_LOAD + 1) : 1;
    localparam logic [c_STALE_W-1:0] c_STALE_INIT = c_STALE_W'(c_STALE_LOAD);
    localparam logic [c_STALE_W-1:0] c_STALE_ONE  = c_STALE_W'(1);

    // Captured reading
    bcd3_t                r_hum;
    bcd3_t                r_temp;
    logic                 r_neg;
    logic                 r_valid;
    logic [c_STALE_W-1:0] r_stale;

    // Scan counters
    logic [c_TICK_W-1:0]  r_tick;
    logic [2:0]           r_idx;

    // Output registers
    logic [6:0]           r_seg;
    logic                 r_dp_n;
    logic [7:0]           r_an_n;

    // Digit mux towards the decoder
    glyph_t               w_glyph;
    logic [3:0]           w_digit;
    logic                 w_dp_n;
    logic [6:0]           w_seg;

    // ------------------------------------------------------------------
    // Capture and staleness. A pulse arriving in the expiry cycle reloads
    // the counter, so valid never drops for it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hum   <= '0;
            r_temp  <= '0;
            r_neg   <= 1'b0;
            r_valid <= 1'b0;
            r_stale <= '0;
        end else if (data_ready) begin
            r_hum   <= humidity_bcd;
            r_temp  <= temperature_bcd;
            r_neg   <= negativo_temp;
            r_valid <= 1'b1;
            r_stale <= c_STALE_INIT;
        end else if (r_valid) begin
            if (r_stale == '0) begin
                r_valid <= 1'b0;
            end else begin
                r_stale <= r_stale - c_STALE_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan: tick counter wraps every c_TICK cycles and advances the digit
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= '0;
            r_idx  <= 3'd0;
        end else if (r_tick == c_TICK_MAX) begin
            r_tick <= '0;
            r_idx  <= r_idx + 3'd1;
        end else begin
            r_tick <= r_tick + c_TICK_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Select what the current digit should show
    // ------------------------------------------------------------------
    always_comb begin
        w_glyph = GLYPH_BLANK;
        w_digit = 4'd0;
        w_dp_n  = 1'b1;
        if (!r_valid) begin
            w_glyph = GLYPH_DASH;
        end else begin
            case (r_idx)
                3'd7: w_glyph = r_neg ? GLYPH_DASH : GLYPH_BLANK;
                3'd6: begin
                    w_digit = r_temp[2];
                    w_glyph = (r_temp[2] == 4'd0) ? GLYPH_BLANK : GLYPH_DIGIT;
                end
                3'd5: begin
                    w_digit = r_temp[1];
                    w_glyph = GLYPH_DIGIT;
                    w_dp_n  = 1'b0;
                end
                3'd4: begin
                    w_digit = r_temp[0];
                    w_glyph = GLYPH_DIGIT;
                end
                3'd2: begin
                    w_digit = r_hum[2];
                    w_glyph = (r_hum[2] == 4'd0) ? GLYPH_BLANK : GLYPH_DIGIT;
                end
                3'd1: begin
                    w_digit = r_hum[1];
                    w_glyph = GLYPH_DIGIT;
                    w_dp_n  = 1'b0;
                end
                3'd0: begin
                    w_digit = r_hum[0];
                    w_glyph = GLYPH_DIGIT;
                end
                default: w_glyph = GLYPH_BLANK;
            endcase
        end
    end

    seg7_decoder u_decoder (
        .i_bcd   (w_digit),
        .i_glyph (w_glyph),
        .o_seg   (w_seg)
    );

    // ------------------------------------------------------------------
    // Segments, dp and anodes update together from one register stage,
    // so the anode and its content can never disagree.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg  <= SEG_BLANK;
            r_dp_n <= 1'b1;
            r_an_n <= 8'hFE;
        end else begin
            r_seg  <= w_seg;
            r_dp_n <= w_dp_n;
            r_an_n <= ~(8'd1 << r_idx);
        end
    end

    assign seg_n = r_seg;
    assign dp_n  = r_dp_n;
    assign an_n  = r_an_n;
    assign valid = r_valid;

endmodule
`default_nettype wire
